// File: rtl/bank_isu_sched.sv
// bank_isu_sched: per-bank collapsing issue queue that parks requests behind outstanding
// linefills and issues oldest-eligible-first. Define ISU_CREDIT_CHECK_EN for channel credits.
module bank_isu_sched #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned IQ_DEPTH    = 8,
    parameter int unsigned SET_W       = 3,
    parameter int unsigned WAY_W       = 3,
    parameter int unsigned ROB_W       = 3,
    parameter int unsigned CREDIT_INIT = 4,
    parameter int unsigned CREDIT_W    = 3,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned CNT_W      = $clog2(IQ_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [CH_W-1:0]   req_ch_id_i,
    input  logic [1:0]        req_opcode_i,
    input  logic [SET_W-1:0]  req_set_i,
    input  logic [WAY_W-1:0]  req_way_i,
    input  logic              req_offset_i,
    input  logic              req_linefill_i,
    input  logic              fill_valid_i,
    input  logic [SET_W-1:0]  fill_set_i,
    input  logic [WAY_W-1:0]  fill_way_i,
    output logic              iss_valid_o,
    input  logic              iss_ready_i,
    output logic [CH_W-1:0]   iss_ch_id_o,
    output logic [1:0]        iss_opcode_o,
    output logic [SET_W-1:0]  iss_set_o,
    output logic [WAY_W-1:0]  iss_way_o,
    output logic              iss_offset_o,
    output logic [ROB_W-1:0]  iss_rob_id_o,
    input  logic [NUM_CH-1:0] credit_ret_i,
    output logic [CNT_W-1:0]  iq_count_o,
    output logic              err_o
);

    localparam int unsigned LINE_W = SET_W + WAY_W;
    localparam int unsigned IDX_W  = $clog2(IQ_DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [1:0]       op;
        logic [SET_W-1:0] set;
        logic [WAY_W-1:0] way;
        logic             off;
        logic [ROB_W-1:0] rob;
        logic             wt;
    } entry_t;

    entry_t                ent_q [IQ_DEPTH];
    entry_t                ent_d [IQ_DEPTH];
    entry_t                ent_w [IQ_DEPTH];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [(1<<LINE_W)-1:0] inflight_q, inflight_d;
    logic [ROB_W-1:0]      rob_q [NUM_CH];
    logic [ROB_W-1:0]      rob_d [NUM_CH];
    entry_t                iss_q, iss_d;
    logic                  iss_valid_q, iss_valid_d;
    logic                  err_q, err_d;

    logic [LINE_W-1:0]     req_line, fill_line;
    logic [IQ_DEPTH-1:0]   elig;
    logic [NUM_CH-1:0]     ch_has_credit;
    logic [NUM_CH-1:0]     credit_take;
    logic                  credit_err;
    logic                  found, load, enq;
    logic [IDX_W-1:0]      sel;
    entry_t                sel_ent, new_ent;

    assign req_line    = {req_set_i, req_way_i};
    assign fill_line   = {fill_set_i, fill_way_i};
    assign req_ready_o = cnt_q < CNT_W'(IQ_DEPTH);
    assign enq         = req_valid_i & req_ready_o;

`ifdef ISU_CREDIT_CHECK_EN
    logic [CREDIT_W-1:0] credit_q [NUM_CH];
    logic [CREDIT_W-1:0] credit_d [NUM_CH];

    // Returns at the reset level flag an error and saturate instead of wrapping.
    always_comb begin
        credit_err = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            credit_d[c]      = credit_q[c];
            ch_has_credit[c] = credit_q[c] != '0;
            if (credit_ret_i[c] && credit_q[c] == CREDIT_W'(CREDIT_INIT)) credit_err = 1'b1;
            if (credit_take[c] && !credit_ret_i[c]) begin
                credit_d[c] = credit_q[c] - 1'b1;
            end else if (!credit_take[c] && credit_ret_i[c] &&
                         credit_q[c] != CREDIT_W'(CREDIT_INIT)) begin
                credit_d[c] = credit_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) credit_q[c] <= CREDIT_W'(CREDIT_INIT);
        end else begin
            for (int c = 0; c < NUM_CH; c++) credit_q[c] <= credit_d[c];
        end
    end
`else
    logic unused_credit;
    assign ch_has_credit = '1;
    assign credit_err    = 1'b0;
    assign unused_credit = ^{credit_ret_i, credit_take, CREDIT_W'(CREDIT_INIT)};
`endif

    always_comb begin
        // Eligibility uses registered wait bits, so a fill wakes an entry one cycle later.
        for (int i = 0; i < IQ_DEPTH; i++) begin
            elig[i] = 1'b0;
            if (CNT_W'(i) < cnt_q && !ent_q[i].wt &&
                (({1'b0, ent_q[i].ch} >= (CH_W+1)'(NUM_CH)) || ch_has_credit[ent_q[i].ch])) begin
                elig[i] = 1'b1;
                for (int j = 0; j < i; j++) begin
                    if ({ent_q[j].set, ent_q[j].way} == {ent_q[i].set, ent_q[i].way}) begin
                        elig[i] = 1'b0;
                    end
                end
            end
        end

        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (elig[i] && !found) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
        sel_ent = ent_q[sel];
        load    = found & (~iss_valid_q | iss_ready_i);

        for (int c = 0; c < NUM_CH; c++) begin
            credit_take[c] = load && (sel_ent.ch == CH_W'(c));
        end

        iss_d       = iss_q;
        iss_valid_d = iss_valid_q & ~iss_ready_i;
        if (load) begin
            iss_d       = sel_ent;
            iss_valid_d = 1'b1;
        end

        new_ent     = '0;
        new_ent.ch  = req_ch_id_i;
        new_ent.op  = req_opcode_i;
        new_ent.set = req_set_i;
        new_ent.way = req_way_i;
        new_ent.off = req_offset_i;
        new_ent.wt  = req_linefill_i |
                      (inflight_q[req_line] & ~(fill_valid_i && fill_line == req_line));
        for (int c = 0; c < NUM_CH; c++) begin
            rob_d[c] = rob_q[c];
            if (req_ch_id_i == CH_W'(c)) begin
                new_ent.rob = rob_q[c];
                if (enq) rob_d[c] = rob_q[c] + 1'b1;
            end
        end

        for (int i = 0; i < IQ_DEPTH; i++) begin
            ent_w[i] = ent_q[i];
            if (fill_valid_i && {ent_q[i].set, ent_q[i].way} == fill_line) ent_w[i].wt = 1'b0;
            ent_d[i] = ent_w[i];
        end
        for (int i = 0; i < IQ_DEPTH - 1; i++) begin
            if (load && IDX_W'(i) >= sel) ent_d[i] = ent_w[i+1];
        end
        if (enq) ent_d[IDX_W'(cnt_q - CNT_W'(load))] = new_ent;
        cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(load);

        inflight_d = inflight_q;
        if (fill_valid_i) inflight_d[fill_line] = 1'b0;
        if (enq && req_linefill_i) inflight_d[req_line] = 1'b1;

        err_d = err_q | credit_err | (enq & req_linefill_i & inflight_q[req_line]) |
                (fill_valid_i & ~inflight_q[fill_line]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= '0;
            for (int c = 0; c < NUM_CH; c++) rob_q[c] <= '0;
            cnt_q       <= '0;
            inflight_q  <= '0;
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= ent_d[i];
            for (int c = 0; c < NUM_CH; c++) rob_q[c] <= rob_d[c];
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            iss_q       <= iss_d;
            iss_valid_q <= iss_valid_d;
            err_q       <= err_d;
        end
    end

    logic unused_iss_wt;
    assign unused_iss_wt = iss_q.wt;

    assign iss_valid_o  = iss_valid_q;
    assign iss_ch_id_o  = iss_q.ch;
    assign iss_opcode_o = iss_q.op;
    assign iss_set_o    = iss_q.set;
    assign iss_way_o    = iss_q.way;
    assign iss_offset_o = iss_q.off;
    assign iss_rob_id_o = iss_q.rob;
    assign iq_count_o   = cnt_q;
    assign err_o        = err_q;

endmodule
